rvc_fetch_aligner: RTL and testbench

- Parametrised RISC-V fetch realigner that sits between the instruction fetch buffer and the decode stage.
- Accepts fetch words of FETCH_HW halfwords and emits one aligned instruction per cycle, either 16-bit (compressed) or 32-bit, together with its PC.
- Holds instructions that straddle fetch-word boundaries.
- Handles redirects that land on an odd halfword, and handles decode backpressure.

---
 rtl/rvc_fetch_aligner.sv | 137 +++++++++++++
 tb/tb_rvc_fetch_aligner.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvc_fetch_aligner.sv
// Purpose: realigns FETCH_HW-halfword fetch words into one 16- or 32-bit RISC-V instruction per cycle.
// Latency: a halfword accepted in cycle N reaches the head in N+1; no same-cycle bypass.
// Backpressure: fetch_ready drops when a whole beat no longer fits; inst_ready low holds the head stable.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   flush, redirect_pc         redirect: empty the buffer, restart at redirect_pc (bit0 ignored)
//   fetch_valid/ready/data     fetch-word handshake, halfword 0 in the LSBs
//   inst_valid/ready           aligned-instruction handshake towards decode
//   inst_data, inst_is_c       instruction (compressed zero-extended) and its size flag
//   inst_pc                    PC of inst_data
//   straddle                   head holds only the lower half of a 32-bit instruction
module rvc_fetch_aligner #(
    parameter int FETCH_HW = 2,
    parameter int BUF_HW   = 6,
    parameter int PC_W     = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic [PC_W-1:0]        redirect_pc,
    input  logic                   fetch_valid,
    output logic                   fetch_ready,
    input  logic [16*FETCH_HW-1:0] fetch_data,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [31:0]            inst_data,
    output logic                   inst_is_c,
    output logic [PC_W-1:0]        inst_pc,
    output logic                   straddle
);

    localparam int CNT_W  = $clog2(BUF_HW + 1);
    localparam int PTR_W  = $clog2(BUF_HW);
    localparam int DROP_W = $clog2(FETCH_HW);

    if ((FETCH_HW != 2 && FETCH_HW != 4) || BUF_HW < FETCH_HW + 2) begin : g_param_check
        $fatal(1, "rvc_fetch_aligner: FETCH_HW must be 2 or 4 and BUF_HW >= FETCH_HW+2");
    end

    logic [15:0]       hbuf_q [BUF_HW];
    logic [15:0]       hbuf_d [BUF_HW];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic [15:0]       h0, h1;
    logic              is_comp;
    logic              push, pop;
    logic [CNT_W-1:0]  push_cnt, pop_cnt;

    // Buffer depth need not be a power of two, so pointers wrap explicitly.
    // n never exceeds BUF_HW, so one conditional subtraction is enough.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int n);
        int s;
        s = int'(p) + n;
        if (s >= BUF_HW) begin
            s = s - BUF_HW;
        end
        return PTR_W'(s);
    endfunction

    // Head decode straight from registered state.
    assign h0      = hbuf_q[head_q];
    assign h1      = hbuf_q[wrap_add(head_q, 1)];
    assign is_comp = (h0[1:0] != 2'b11);

    assign inst_valid = is_comp ? (count_q >= CNT_W'(1)) : (count_q >= CNT_W'(2));
    assign inst_data  = is_comp ? {16'h0000, h0} : {h1, h0};
    // Qualified with a non-empty buffer so an empty aligner reports a 32-bit-neutral 0.
    assign inst_is_c  = is_comp && (count_q != '0);
    assign inst_pc    = pc_q;
    assign straddle   = (count_q == CNT_W'(1)) && !is_comp;

    // Deliberately ignores a concurrent pop: only a whole free beat's worth of space counts.
    assign fetch_ready = !flush && ((int'(count_q) + FETCH_HW) <= BUF_HW);

    assign push     = fetch_valid && fetch_ready;
    assign pop      = inst_valid && inst_ready && !flush;
    assign push_cnt = push ? CNT_W'(FETCH_HW - int'(drop_q)) : '0;
    assign pop_cnt  = pop ? (is_comp ? CNT_W'(1) : CNT_W'(2)) : '0;

    always_comb begin
        hbuf_d  = hbuf_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            pc_d    = redirect_pc & ~PC_W'(1);
            // Halfwords of the next beat that sit below the redirect target are skipped.
            drop_d  = redirect_pc[DROP_W:1];
        end else begin
            if (push) begin
                for (int i = 0; i < FETCH_HW; i++) begin
                    if (i >= int'(drop_q)) begin
                        hbuf_d[wrap_add(tail_q, i - int'(drop_q))] = fetch_data[16*i +: 16];
                    end
                end
                tail_d = wrap_add(tail_q, int'(push_cnt));
                drop_d = '0;
            end
            if (pop) begin
                head_d = wrap_add(head_q, int'(pop_cnt));
                pc_d   = pc_q + (is_comp ? PC_W'(2) : PC_W'(4));
            end
            count_d = count_q + push_cnt - pop_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BUF_HW; i++) begin
                hbuf_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pc_q    <= '0;
            drop_q  <= '0;
        end else begin
            hbuf_q  <= hbuf_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
module tb_rvc_fetch_aligner;

    localparam int F = 2;
    localparam int B = 6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic [31:0] fetch_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic        inst_is_c;
    logic [31:0] inst_pc;
    logic        straddle;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: the buffered halfwords as a queue, plus pc and pending drop.
    logic [15:0] mq[$];
    logic [31:0] mpc = '0;
    int          mdrop = 0;

    rvc_fetch_aligner #(.FETCH_HW(F), .BUF_HW(B), .PC_W(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_data  (fetch_data),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .inst_is_c   (inst_is_c),
        .inst_pc     (inst_pc),
        .straddle    (straddle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit head_comp();
        if (mq.size() == 0) return 1'b1;
        return mq[0][1:0] != 2'b11;
    endfunction

    function automatic bit head_valid();
        int sz = mq.size();
        if (head_comp()) return sz >= 1;
        return sz >= 2;
    endfunction

    task automatic check_all();
        bit comp;
        bit ev;
        comp = head_comp();
        ev   = head_valid();
        chk("fetch_ready", fetch_ready, !flush && (mq.size() + F <= B));
        chk("inst_valid", inst_valid, ev);
        chk("straddle", straddle, (mq.size() == 1) && !comp);
        chk("inst_pc", inst_pc, mpc);
        if (ev) begin
            chk("inst_is_c", inst_is_c, comp);
            if (comp) chk("inst_data", inst_data, {16'h0000, mq[0]});
            else      chk("inst_data", inst_data, {mq[1], mq[0]});
        end
    endtask

    task automatic model_update();
        bit comp;
        bit ev;
        bit er;
        comp = head_comp();
        ev   = head_valid();
        er   = !flush && (mq.size() + F <= B);
        if (flush) begin
            mq.delete();
            mpc   = redirect_pc & ~32'd1;
            mdrop = (redirect_pc >> 1) % F;
        end else begin
            if (ev && inst_ready) begin
                void'(mq.pop_front());
                if (!comp) void'(mq.pop_front());
                mpc = mpc + (comp ? 32'd2 : 32'd4);
            end
            if (fetch_valid && er) begin
                for (int i = mdrop; i < F; i++) mq.push_back(fetch_data[16*i +: 16]);
                mdrop = 0;
            end
        end
    endtask

    // Inputs are set at the negedge before calling; outputs are checked, then the edge is taken.
    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive(input bit f, input logic [31:0] rpc, input bit fv,
                         input logic [31:0] fd, input bit ir);
        flush       = f;
        redirect_pc = rpc;
        fetch_valid = fv;
        fetch_data  = fd;
        inst_ready  = ir;
    endtask

    function automatic logic [15:0] rand_hw();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 3))
            0: v[1:0] = 2'b11;
            1: v[1:0] = 2'b11;
            2: v = 16'h0000;
            default: v[1:0] = 2'($urandom_range(0, 2));
        endcase
        return v;
    endfunction

    initial begin
        // Reset values
        #2;
        chk("rst_fetch_ready", fetch_ready, 1'b1);
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_inst_is_c", inst_is_c, 1'b0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_straddle", straddle, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Aligned 32-bit stream
        drive(1, 32'h100, 0, 32'h0, 1); step();
        drive(0, 32'h0, 1, 32'h00A00093, 1); step();
        chk("t1_valid0", inst_valid, 1'b1);
        chk("t1_data0", inst_data, 32'h00A00093);
        chk("t1_pc0", inst_pc, 32'h100);
        drive(0, 32'h0, 1, 32'h00B00113, 1); step();
        chk("t1_data1", inst_data, 32'h00B00113);
        chk("t1_isc1", inst_is_c, 1'b0);
        chk("t1_pc1", inst_pc, 32'h104);
        drive(0, 32'h0, 0, 32'h0, 1); step();

        // Mixed compressed / 32-bit stream with a straddle
        drive(1, 32'h100, 0, 32'h0, 1); step();
        drive(0, 32'h0, 1, {16'h4505, 16'h4585}, 1); step();
        chk("t2_c0", inst_data, 32'h4585);
        chk("t2_c0_isc", inst_is_c, 1'b1);
        chk("t2_c0_pc", inst_pc, 32'h100);
        drive(0, 32'h0, 1, {16'h0093, 16'h4601}, 1); step();
        chk("t2_c1", inst_data, 32'h4505);
        chk("t2_c1_pc", inst_pc, 32'h102);
        drive(0, 32'h0, 0, 32'h0, 1); step();
        chk("t2_c2", inst_data, 32'h4601);
        chk("t2_c2_pc", inst_pc, 32'h104);
        step();
        chk("t2_straddle", straddle, 1'b1);
        chk("t2_strad_nv", inst_valid, 1'b0);
        drive(0, 32'h0, 1, {16'hFFFF, 16'h00A0}, 1); step();
        chk("t2_w_valid", inst_valid, 1'b1);
        chk("t2_w_data", inst_data, 32'h00A00093);
        chk("t2_w_pc", inst_pc, 32'h106);
        drive(0, 32'h0, 0, 32'h0, 1); step();
        step();

        // Odd-halfword redirect drops the low halfword of the first beat
        drive(1, 32'h202, 0, 32'h0, 1); step();
        drive(0, 32'h0, 1, {16'h4505, 16'h1234}, 1); step();
        chk("t3_data", inst_data, 32'h4505);
        chk("t3_pc", inst_pc, 32'h202);
        chk("t3_isc", inst_is_c, 1'b1);
        drive(0, 32'h0, 0, 32'h0, 1); step();
        chk("t3_empty", inst_valid, 1'b0);

        // Backpressure until full, then drain in order
        drive(1, 32'h300, 0, 32'h0, 0); step();
        for (int k = 0; k < 4; k++) begin
            drive(0, 32'h0, 1, {16'h4001 + 16'((2*k+1) << 4), 16'h4001 + 16'((2*k) << 4)}, 0);
            step();
            chk("t4_hold_data", inst_data, 32'h4001);
            chk("t4_hold_pc", inst_pc, 32'h300);
        end
        #1;
        chk("t4_full_ready", fetch_ready, 1'b0);
        for (int k = 0; k < 6; k++) begin
            drive(0, 32'h0, 0, 32'h0, 1);
            #1;
            chk("t4_drain_data", inst_data, 32'h4001 + 32'(k << 4));
            chk("t4_drain_pc", inst_pc, 32'h300 + 32'(2*k));
            step();
        end
        chk("t4_drained", inst_valid, 1'b0);

        // Flush while straddling, with a concurrent fetch_valid
        drive(1, 32'h500, 0, 32'h0, 1); step();
        drive(0, 32'h0, 1, {16'h0093, 16'h4001}, 1); step();
        drive(0, 32'h0, 0, 32'h0, 1); step();
        chk("t5_straddle", straddle, 1'b1);
        drive(1, 32'h601, 1, {16'h4101, 16'h4201}, 1); step();
        chk("t5_nv", inst_valid, 1'b0);
        chk("t5_nstrad", straddle, 1'b0);
        chk("t5_pc", inst_pc, 32'h600);
        drive(0, 32'h0, 0, 32'h0, 1); step();
        chk("t5_ignored", inst_valid, 1'b0);

        // Asynchronous reset mid-stream with three halfwords buffered
        drive(1, 32'h402, 0, 32'h0, 0); step();
        drive(0, 32'h0, 1, {16'h0093, 16'h1111}, 0); step();
        drive(0, 32'h0, 1, {16'h4501, 16'h00A0}, 0); step();
        drive(0, 32'h0, 0, 32'h0, 0);
        #1;
        chk("t6_pre_valid", inst_valid, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_ready", fetch_ready, 1'b1);
        chk("t6_rst_valid", inst_valid, 1'b0);
        chk("t6_rst_data", inst_data, 32'h0);
        chk("t6_rst_isc", inst_is_c, 1'b0);
        chk("t6_rst_pc", inst_pc, 32'h0);
        chk("t6_rst_strad", straddle, 1'b0);
        mq.delete();
        mpc = '0;
        mdrop = 0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("t6_rel_ready", fetch_ready, 1'b1);
        @(negedge clk);

        // Randomised traffic against the queue model
        for (int c = 0; c < 1500; c++) begin
            logic [31:0] rpc;
            rpc = $urandom;
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
            drive($urandom_range(0, 39) == 0, rpc, $urandom_range(0, 3) != 0,
                  {rand_hw(), rand_hw()}, $urandom_range(0, 2) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
